// File: rtl/rgb_pwm_pkg.sv
// rgb_pwm_pkg: register addresses, CTRL bit positions and FSM state type shared by rgb_pwm_ctrl
package rgb_pwm_pkg;
  localparam logic [2:0] ADDR_R        = 3'd0;
  localparam logic [2:0] ADDR_G        = 3'd1;
  localparam logic [2:0] ADDR_B        = 3'd2;
  localparam logic [2:0] ADDR_PRESCALE = 3'd3;
  localparam logic [2:0] ADDR_STEP     = 3'd4;
  localparam logic [2:0] ADDR_CTRL     = 3'd5;
  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;
  localparam int CTRL_JUMP  = 2;
  typedef enum logic [1:0] {ST_IDLE, ST_FADING, ST_DONE} state_t;
endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: one LED channel; shadow duty (jump/step toward target), boundary-latched active duty, registered compare output o_pwm
module pwm_channel #(
  parameter int PWM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PWM_W-1:0] i_cnt,
  input  logic [PWM_W-1:0] i_target,
  input  logic             i_boundary,
  input  logic             i_jump,
  input  logic             i_step,
  output logic [PWM_W-1:0] o_shadow,
  output logic             o_pwm
);
  logic [PWM_W-1:0] r_shadow, r_active, w_shadow_nxt;
  logic             r_pwm;
  always_comb
    w_shadow_nxt = i_jump                ? i_target :
                   !i_step               ? r_shadow :
                   r_shadow < i_target   ? r_shadow + 1'b1 :
                   r_shadow > i_target   ? r_shadow - 1'b1 : r_shadow;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow <= '0;
      r_active <= '0;
      r_pwm    <= 1'b0;
    end else begin
      r_shadow <= w_shadow_nxt;
      if (i_boundary) r_active <= r_shadow;
      r_pwm <= i_cnt < r_active;
    end
  end
  assign o_shadow = r_shadow;
  assign o_pwm    = r_pwm;
endmodule

// File: rtl/rgb_pwm_ctrl.sv
// rgb_pwm_ctrl: RGB PWM fader; HCLK/HRESET, cfg_valid/ready/addr/wdata write port, red/green/blue_pwm outputs, busy while fading, done_irq pulse
module rgb_pwm_ctrl
  import rgb_pwm_pkg::*;
#(
  parameter int PWM_W = 8,
  parameter int PRE_W = 16
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [2:0]  cfg_addr,
  input  logic [15:0] cfg_wdata,
  output logic        red_pwm,
  output logic        green_pwm,
  output logic        blue_pwm,
  output logic        busy,
  output logic        done_irq
);
  localparam logic [PWM_W-1:0] CNT_MAX = '1;
  state_t           r_state, w_state_nxt;
  logic [PRE_W-1:0] r_prescale, r_pre_cnt;
  logic [PWM_W-1:0] r_pwm_cnt, r_step, r_step_cnt;
  logic [PWM_W-1:0] r_tgt [3];
  logic [PWM_W-1:0] w_shadow [3];
  logic [2:0]       w_pwm;
  logic             w_wr, w_ctrl, w_fading, w_start, w_abort, w_jump;
  logic             w_tick, w_boundary, w_step, w_settled;
  assign w_fading   = r_state == ST_FADING;
  assign cfg_ready  = !HRESET && (!w_fading || cfg_addr == ADDR_CTRL);
  assign w_wr       = cfg_valid && cfg_ready;
  assign w_ctrl     = w_wr && cfg_addr == ADDR_CTRL;
  assign w_start    = w_ctrl && !w_fading && cfg_wdata[CTRL_START];
  assign w_abort    = w_ctrl && w_fading && cfg_wdata[CTRL_ABORT];
  assign w_jump     = w_ctrl && !w_fading && cfg_wdata[CTRL_JUMP];
  assign w_tick     = r_pre_cnt == '0;
  assign w_boundary = w_tick && r_pwm_cnt == CNT_MAX;
  assign w_step     = w_fading && w_boundary && r_step_cnt == r_step && !w_abort;
  assign w_settled  = w_shadow[0] == r_tgt[0] && w_shadow[1] == r_tgt[1] && w_shadow[2] == r_tgt[2];
  always_comb
    w_state_nxt = w_fading ? (w_abort ? ST_IDLE : (w_step && w_settled) ? ST_DONE : ST_FADING) :
                  w_start  ? ST_FADING : ST_IDLE;
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state    <= ST_IDLE;
      r_prescale <= '0;
      r_pre_cnt  <= '0;
      r_pwm_cnt  <= '0;
      r_step     <= '0;
      r_step_cnt <= '0;
      for (int i = 0; i < 3; i++) r_tgt[i] <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pre_cnt <= w_tick ? r_prescale : r_pre_cnt - 1'b1;
      if (w_tick) r_pwm_cnt <= r_pwm_cnt + 1'b1;
      if (w_start) r_step_cnt <= '0;
      else if (w_fading && w_boundary) r_step_cnt <= r_step_cnt == r_step ? '0 : r_step_cnt + 1'b1;
      if (w_wr && cfg_addr == ADDR_PRESCALE) r_prescale <= cfg_wdata[PRE_W-1:0];
      if (w_wr && cfg_addr == ADDR_STEP) r_step <= cfg_wdata[PWM_W-1:0];
      for (int i = 0; i < 3; i++) if (w_wr && cfg_addr == ADDR_R + 3'(i)) r_tgt[i] <= cfg_wdata[PWM_W-1:0];
    end
  end
  for (genvar g = 0; g < 3; g++) begin : g_ch
    pwm_channel #(.PWM_W(PWM_W)) u_ch (
      .clk       (HCLK),
      .rst       (HRESET),
      .i_cnt     (r_pwm_cnt),
      .i_target  (r_tgt[g]),
      .i_boundary(w_boundary),
      .i_jump    (w_jump),
      .i_step    (w_step && !w_settled),
      .o_shadow  (w_shadow[g]),
      .o_pwm     (w_pwm[g])
    );
  end
  assign red_pwm   = w_pwm[0];
  assign green_pwm = w_pwm[1];
  assign blue_pwm  = w_pwm[2];
  assign busy      = w_fading;
  assign done_irq  = r_state == ST_DONE;
endmodule

// File: tb/tb_rgb_pwm_ctrl.sv
// tb_rgb_pwm_ctrl: directed plus randomized checks of rgb_pwm_ctrl against period-level arithmetic expectations
module tb_rgb_pwm_ctrl;
  logic        HCLK = 1'b0, HRESET = 1'b1, cfg_valid = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [15:0] cfg_wdata = '0;
  logic        cfg_ready, red_pwm, green_pwm, blue_pwm, busy, done_irq;
  int n_asserts = 0, n_fails = 0;
  int n = 0, dones = 0, last_done = -1;
  int duty [3];
  int cr, cg, cb, s, b, d0, cnt, hi, k, maxd, stp, t [3];
  rgb_pwm_ctrl dut (
    .HCLK(HCLK), .HRESET(HRESET), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .red_pwm(red_pwm), .green_pwm(green_pwm),
    .blue_pwm(blue_pwm), .busy(busy), .done_irq(done_irq)
  );
  always #5 HCLK = ~HCLK;
  initial begin
    #3000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic tick1();
    @(posedge HCLK);
    #1;
    n++;
    if (done_irq === 1'b1) begin
      dones++;
      last_done = n;
    end
  endtask
  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    cfg_addr = a;
    cfg_wdata = d;
    cfg_valid = 1'b1;
    tick1();
    cfg_valid = 1'b0;
  endtask
  task automatic wait_to(input int tgt_n);
    while (n < tgt_n) tick1();
  endtask
  task automatic meas(input int len, output int r, output int g, output int bl);
    r = 0; g = 0; bl = 0;
    repeat (len) begin
      tick1();
      r += int'(red_pwm); g += int'(green_pwm); bl += int'(blue_pwm);
    end
  endtask
  function automatic int nb(input int x);
    return (x / 256 + 1) * 256;
  endfunction
  initial begin
    // reset behaviour
    tick1(); tick1();
    chk("rst_ready", cfg_ready, 0);
    chk("rst_outs", {red_pwm, green_pwm, blue_pwm, busy, done_irq}, 0);
    HRESET = 1'b0;
    n = 0;
    #1;
    chk("rst_ready_after", cfg_ready, 1);
    tick1();
    chk("rst_outs_after", {red_pwm, green_pwm, blue_pwm, busy, done_irq}, 0);
    // red duty 64 via jump, PRESCALE 0
    wr(3'd0, 16'd64);
    wr(3'd5, 16'h4);
    b = nb(n);
    wait_to(b + 1);
    chk("r64_first", red_pwm, 1);
    wait_to(b + 64);
    chk("r64_last_high", red_pwm, 1);
    tick1();
    chk("r64_first_low", red_pwm, 0);
    meas(256, cr, cg, cb);
    chk("r64_count", cr, 64);
    chk("g_zero", cg, 0);
    chk("b_zero", cb, 0);
    // duty 255, then mid-period change
    wr(3'd0, 16'd255);
    wr(3'd5, 16'h4);
    wait_to(nb(n));
    meas(256, cr, cg, cb);
    chk("r255_count", cr, 255);
    wait_to(n + 128);
    wr(3'd0, 16'd0);
    wr(3'd5, 16'h4);
    b = nb(n);
    cnt = 0; hi = 0;
    while (n < b - 1) begin
      tick1();
      cnt++;
      hi += int'(red_pwm);
    end
    chk("mid_period_hold", hi, cnt);
    tick1();
    meas(256, cr, cg, cb);
    chk("r0_after_boundary", cr, 0);
    duty[0] = 0; duty[1] = 0; duty[2] = 0;
    // random jumps
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 3; c++) begin
        duty[c] = int'($urandom_range(0, 255));
        wr(3'(c), 16'(duty[c]));
      end
      wr(3'd5, 16'h4);
      wait_to(nb(n));
      meas(256, cr, cg, cb);
      chk("rand_jump_r", cr, duty[0]);
      chk("rand_jump_g", cg, duty[1]);
      chk("rand_jump_b", cb, duty[2]);
    end
    // start with targets already equal, STEP=2
    wr(3'd4, 16'd2);
    d0 = dones;
    wr(3'd5, 16'h1);
    s = n;
    chk("eq_busy", busy, 1);
    while (dones == d0 && n < s + 2000) tick1();
    chk("eq_done_edge", last_done, nb(s) + 512);
    tick1();
    chk("eq_done_pulse", {busy, done_irq}, 0);
    chk("eq_done_count", dones - d0, 1);
    // random fades
    for (int r = 0; r < 2; r++) begin
      maxd = 0;
      for (int c = 0; c < 3; c++) begin
        t[c] = duty[c] + int'($urandom_range(0, 12)) - 6;
        if (t[c] < 0) t[c] = 0;
        if (t[c] > 255) t[c] = 255;
        if ((t[c] > duty[c] ? t[c] - duty[c] : duty[c] - t[c]) > maxd)
          maxd = t[c] > duty[c] ? t[c] - duty[c] : duty[c] - t[c];
        wr(3'(c), 16'(t[c]));
      end
      stp = int'($urandom_range(0, 2));
      wr(3'd4, 16'(stp));
      d0 = dones;
      wr(3'd5, 16'h1);
      s = n;
      chk("fade_busy", busy, 1);
      k = (maxd + 1) * (stp + 1);
      while (dones == d0 && n < s + (k + 2) * 256) tick1();
      chk("fade_done_edge", last_done, nb(s) + (k - 1) * 256);
      tick1();
      chk("fade_idle", busy, 0);
      meas(256, cr, cg, cb);
      chk("fade_r", cr, t[0]);
      chk("fade_g", cg, t[1]);
      chk("fade_b", cb, t[2]);
      chk("fade_single_irq", dones - d0, 1);
      for (int c = 0; c < 3; c++) duty[c] = t[c];
    end
    // green 0 -> 200, abort after 10 periods
    wr(3'd1, 16'd0);
    wr(3'd5, 16'h4);
    wr(3'd1, 16'd200);
    wr(3'd4, 16'd0);
    d0 = dones;
    wr(3'd5, 16'h1);
    s = n;
    wait_to(nb(s) + 9 * 256 + 10);
    wr(3'd5, 16'h3);
    chk("abort_idle", busy, 0);
    wait_to(nb(n));
    meas(256, cr, cg, cb);
    chk("abort_g_frozen", cg, 10);
    chk("abort_r_kept", cr, duty[0]);
    chk("abort_b_kept", cb, duty[2]);
    chk("abort_no_irq", dones - d0, 0);
    // reset in the middle of a fade
    wr(3'd1, 16'd100);
    wr(3'd5, 16'h1);
    repeat (300) tick1();
    chk("midfade_busy", busy, 1);
    d0 = dones;
    HRESET = 1'b1;
    tick1();
    chk("midfade_rst_outs", {red_pwm, green_pwm, blue_pwm, busy, done_irq}, 0);
    HRESET = 1'b0;
    n = 0;
    repeat (600) tick1();
    chk("midfade_no_irq", dones - d0, 0);
    meas(256, cr, cg, cb);
    chk("midfade_duties_zero", cr + cg + cb, 0);
    // PRESCALE=3, red 0 -> 4, back-pressure during fade
    wr(3'd3, 16'd3);
    wr(3'd0, 16'd4);
    d0 = dones;
    wr(3'd5, 16'h1);
    s = n;
    chk("ps_busy", busy, 1);
    cfg_addr = 3'd5; cfg_wdata = 16'h0; cfg_valid = 1'b1;
    #1;
    chk("bp_ctrl_ready", cfg_ready, 1);
    tick1();
    cfg_addr = 3'd0; cfg_wdata = 16'd4;
    #1;
    chk("bp_addr0_blocked", cfg_ready, 0);
    while (cfg_ready !== 1'b1 && n < s + 6000) tick1();
    chk("bp_ready_at_done", done_irq, 1);
    tick1();
    cfg_valid = 1'b0;
    chk("ps_done_window", (last_done > s + 4096) && (last_done <= s + 5120), 1);
    repeat (20) tick1();
    chk("ps_single_irq", dones - d0, 1);
    chk("ps_idle", busy, 0);
    meas(1024, cr, cg, cb);
    chk("ps_r4_count", cr, 16);
    chk("ps_gb_zero", cg + cb, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end
endmodule

// File: doc/rgb_pwm_ctrl.md
RGB_PWM_CTRL -- requirements
Module: rgb_pwm_ctrl

Interface
REQ-001 SHALL have parameter PWM_W, default 8, PWM counter/duty width.
REQ-002 SHALL have parameter PRE_W, default 16, prescaler width.
REQ-003 SHALL have port HCLK  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port HRESET  in  1  synchronous, active-high reset.
REQ-005 SHALL have port cfg_valid  in  1  config write request.
REQ-006 SHALL have port cfg_ready  out  1  config write accept; write occurs when cfg_valid && cfg_ready.
REQ-007 SHALL have port cfg_addr  in  3  register select: 0/1/2 target R/G/B, 3 PRESCALE, 4 STEP, 5 CTRL.
REQ-008 SHALL have port cfg_wdata  in  16  write data; targets and STEP use [PWM_W-1:0], CTRL uses bit0 start, bit1 abort, bit2 jump.
REQ-009 SHALL have ports red_pwm, green_pwm, blue_pwm  out  1 each  registered PWM outputs to the LED driver.
REQ-010 SHALL have port busy  out  1  high while state is FADING.
REQ-011 SHALL have port done_irq  out  1  one-cycle pulse on fade completion.

Function
REQ-012 Prescaler: SHALL count HCLK cycles and assert an internal tick every PRESCALE+1 cycles; PRESCALE=0 yields a tick every cycle; a new PRESCALE value takes effect at the next prescaler reload.
REQ-013 PWM counter: SHALL increment by 1 per tick, wrap 2^PWM_W-1 -> 0; wrap cycle is the "period boundary".
REQ-014 Each output SHALL be high when pwm_cnt < duty_active of its channel, registered (1-cycle latency); duty 0 -> constant low; duty 255 -> high 255 of 256 ticks.
REQ-015 duty_active SHALL update only at a period boundary, from duty_shadow, so no glitch or runt pulse occurs mid-period.
REQ-016 FSM states: IDLE, FADING, DONE.
REQ-017 IDLE: cfg_ready=1 for all addresses; CTRL.start -> FADING next cycle; CTRL.jump copies targets to duty_shadow (visible at next boundary), no state change.
REQ-018 FADING: at each step event (every STEP+1 period boundaries; STEP=0 means every boundary), each duty_shadow moves 1 toward its target; channels already equal stay.
REQ-019 FADING: when all three duty_shadow equal targets at a step event, transition to DONE.
REQ-020 FADING: cfg_ready SHALL be 1 only when cfg_addr==5 (CTRL); writes to 0..4 are back-pressured.
REQ-021 CTRL.abort in FADING -> IDLE next cycle, duty_shadow frozen, no done_irq; start and abort in one write: abort wins.
REQ-022 DONE: done_irq=1 for exactly that cycle, then IDLE; cfg_ready=1.
REQ-023 Start with targets already equal to duties SHALL complete at the first step event (done_irq within STEP+1 periods).
REQ-024 Step counter SHALL clear on entry to FADING; duty arithmetic never wraps (saturates at target).

Reset
REQ-025 On HRESET: all duties, targets 0; PRESCALE 0; STEP 0; counters 0; state IDLE.
REQ-026 During and the cycle after reset: red/green/blue_pwm=0, busy=0, done_irq=0, cfg_ready=0 during reset, 1 after.
REQ-027 Reset mid-fade SHALL discard the fade with no done_irq.

Structure
REQ-028 Package rgb_pwm_pkg SHALL hold register address constants, CTRL bit indices, and the FSM state enum.
REQ-029 One sub-module pwm_channel (shadow/active duty, compare, registered output) SHALL be instantiated three times.

Verification
REQ-030 Reset, PRESCALE=0, target R=64, CTRL.jump -> from the next boundary red_pwm high 64 of every 256 cycles; G/B stay 0.
REQ-031 PRESCALE=3, R target 0->4, STEP=0, start -> busy 1; duty steps 1,2,3,4 over 4 periods of 1024 cycles; single done_irq; busy 0.
REQ-032 During FADING write addr 0 -> cfg_ready=0, held until DONE, then accepted; write addr 5 accepted immediately.
REQ-033 Fade G 0->200, abort after 10 periods -> IDLE, G duty frozen at 10, no done_irq.
REQ-034 Start with targets == duties, STEP=2 -> done_irq exactly at 3rd period boundary.
REQ-035 Duty 255 -> output low 1 tick per period; duty changed mid-period -> no mid-period edge change.
